// File: rtl/reservation_station.sv
// Reservation station: buffers issued ALU instructions until both operands are ready,
// snoops the ALU/LSB CDB, and dispatches one ready entry per cycle. Optional stats: RS_STAT_EN.
module reservation_station #(
   parameter int RS_SIZE = 16,
   parameter int TAG_W   = 5
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             rdy,
   input  logic             wrong_commit,
   input  logic             issue_valid,
   input  logic [6:0]       issue_op,
   input  logic [31:0]      issue_imm,
   input  logic [31:0]      issue_pc,
   input  logic [TAG_W-1:0] issue_Qi,
   input  logic [TAG_W-1:0] issue_Qj,
   input  logic [31:0]      issue_Vi,
   input  logic [31:0]      issue_Vj,
   input  logic [TAG_W-1:0] issue_rob_id,
   output logic             rs_full,
   input  logic             alu_valid,
   input  logic [TAG_W-1:0] alu_rob_id,
   input  logic [31:0]      alu_res,
   input  logic             lsb_valid,
   input  logic [TAG_W-1:0] lsb_rob_id,
   input  logic [31:0]      lsb_res,
   output logic             to_alu_valid,
   output logic [6:0]       to_alu_op,
   output logic [31:0]      to_alu_Vi,
   output logic [31:0]      to_alu_Vj,
   output logic [31:0]      to_alu_imm,
   output logic [31:0]      to_alu_pc,
   output logic [TAG_W-1:0] to_alu_rob_id
`ifdef RS_STAT_EN
   ,
   output logic [31:0]      stat_issue_cnt,
   output logic [31:0]      stat_dispatch_cnt,
   output logic [31:0]      stat_full_cycles
`endif
);

   localparam int IDX_W = (RS_SIZE > 1) ? $clog2(RS_SIZE) : 1;
   localparam int CNT_W = $clog2(RS_SIZE) + 1;

   logic [RS_SIZE-1:0] busy_q, busy_d;
   logic [6:0]         op_q  [RS_SIZE];
   logic [6:0]         op_d  [RS_SIZE];
   logic [31:0]        imm_q [RS_SIZE];
   logic [31:0]        imm_d [RS_SIZE];
   logic [31:0]        pc_q  [RS_SIZE];
   logic [31:0]        pc_d  [RS_SIZE];
   logic [31:0]        vi_q  [RS_SIZE];
   logic [31:0]        vi_d  [RS_SIZE];
   logic [31:0]        vj_q  [RS_SIZE];
   logic [31:0]        vj_d  [RS_SIZE];
   logic [TAG_W-1:0]   qi_q  [RS_SIZE];
   logic [TAG_W-1:0]   qi_d  [RS_SIZE];
   logic [TAG_W-1:0]   qj_q  [RS_SIZE];
   logic [TAG_W-1:0]   qj_d  [RS_SIZE];
   logic [TAG_W-1:0]   rob_q [RS_SIZE];
   logic [TAG_W-1:0]   rob_d [RS_SIZE];
   logic [CNT_W-1:0]   count_q, count_d;

   logic               to_alu_valid_q, to_alu_valid_d;
   logic [6:0]         to_alu_op_q, to_alu_op_d;
   logic [31:0]        to_alu_vi_q, to_alu_vi_d;
   logic [31:0]        to_alu_vj_q, to_alu_vj_d;
   logic [31:0]        to_alu_imm_q, to_alu_imm_d;
   logic [31:0]        to_alu_pc_q, to_alu_pc_d;
   logic [TAG_W-1:0]   to_alu_rob_q, to_alu_rob_d;

   logic               flush;
   logic               sel_found, free_found;
   logic [IDX_W-1:0]   sel_idx, free_idx;
   logic               alloc_en, disp_en;

   // Tag 0 means "value already valid" and must never match a broadcast.
   function automatic logic cdb_hit(input logic [TAG_W-1:0] q);
      return (q != '0) && ((alu_valid && alu_rob_id == q) || (lsb_valid && lsb_rob_id == q));
   endfunction

   function automatic logic [31:0] cdb_val(input logic [TAG_W-1:0] q);
      return (alu_valid && alu_rob_id == q) ? alu_res : lsb_res;
   endfunction

   assign flush    = rst || wrong_commit;
   assign rs_full  = (count_q + CNT_W'(issue_valid)) >= CNT_W'(RS_SIZE);
   assign alloc_en = rdy && !flush && issue_valid && free_found;
   assign disp_en  = rdy && !flush && sel_found;

   // Descending scan so the lowest matching index wins.
   always_comb begin
      sel_found  = 1'b0;
      sel_idx    = '0;
      free_found = 1'b0;
      free_idx   = '0;
      for (int i = RS_SIZE - 1; i >= 0; i--) begin
         if (busy_q[i] && qi_q[i] == '0 && qj_q[i] == '0) begin
            sel_found = 1'b1;
            sel_idx   = IDX_W'(i);
         end
         if (!busy_q[i]) begin
            free_found = 1'b1;
            free_idx   = IDX_W'(i);
         end
      end
   end

   always_comb begin
      busy_d         = busy_q;
      op_d           = op_q;
      imm_d          = imm_q;
      pc_d           = pc_q;
      vi_d           = vi_q;
      vj_d           = vj_q;
      qi_d           = qi_q;
      qj_d           = qj_q;
      rob_d          = rob_q;
      count_d        = count_q;
      to_alu_valid_d = to_alu_valid_q;
      to_alu_op_d    = to_alu_op_q;
      to_alu_vi_d    = to_alu_vi_q;
      to_alu_vj_d    = to_alu_vj_q;
      to_alu_imm_d   = to_alu_imm_q;
      to_alu_pc_d    = to_alu_pc_q;
      to_alu_rob_d   = to_alu_rob_q;
      if (rdy) begin
         for (int i = 0; i < RS_SIZE; i++) begin
            if (busy_q[i] && cdb_hit(qi_q[i])) begin
               vi_d[i] = cdb_val(qi_q[i]);
               qi_d[i] = '0;
            end
            if (busy_q[i] && cdb_hit(qj_q[i])) begin
               vj_d[i] = cdb_val(qj_q[i]);
               qj_d[i] = '0;
            end
         end
         to_alu_valid_d = disp_en;
         if (disp_en) begin
            busy_d[sel_idx] = 1'b0;
            to_alu_op_d     = op_q[sel_idx];
            to_alu_vi_d     = vi_q[sel_idx];
            to_alu_vj_d     = vj_q[sel_idx];
            to_alu_imm_d    = imm_q[sel_idx];
            to_alu_pc_d     = pc_q[sel_idx];
            to_alu_rob_d    = rob_q[sel_idx];
         end
         // The free slot comes from start-of-cycle state, so it never aliases the dispatched one.
         if (alloc_en) begin
            busy_d[free_idx] = 1'b1;
            op_d[free_idx]   = issue_op;
            imm_d[free_idx]  = issue_imm;
            pc_d[free_idx]   = issue_pc;
            rob_d[free_idx]  = issue_rob_id;
            vi_d[free_idx]   = cdb_hit(issue_Qi) ? cdb_val(issue_Qi) : issue_Vi;
            qi_d[free_idx]   = cdb_hit(issue_Qi) ? '0 : issue_Qi;
            vj_d[free_idx]   = cdb_hit(issue_Qj) ? cdb_val(issue_Qj) : issue_Vj;
            qj_d[free_idx]   = cdb_hit(issue_Qj) ? '0 : issue_Qj;
         end
         count_d = count_q + CNT_W'(alloc_en) - CNT_W'(disp_en);
      end
   end

   always_ff @(posedge clk) begin
      op_q  <= op_d;
      imm_q <= imm_d;
      pc_q  <= pc_d;
      vi_q  <= vi_d;
      vj_q  <= vj_d;
      qi_q  <= qi_d;
      qj_q  <= qj_d;
      rob_q <= rob_d;
      if (flush) begin
         busy_q         <= '0;
         count_q        <= '0;
         to_alu_valid_q <= 1'b0;
         to_alu_op_q    <= '0;
         to_alu_vi_q    <= '0;
         to_alu_vj_q    <= '0;
         to_alu_imm_q   <= '0;
         to_alu_pc_q    <= '0;
         to_alu_rob_q   <= '0;
      end else begin
         busy_q         <= busy_d;
         count_q        <= count_d;
         to_alu_valid_q <= to_alu_valid_d;
         to_alu_op_q    <= to_alu_op_d;
         to_alu_vi_q    <= to_alu_vi_d;
         to_alu_vj_q    <= to_alu_vj_d;
         to_alu_imm_q   <= to_alu_imm_d;
         to_alu_pc_q    <= to_alu_pc_d;
         to_alu_rob_q   <= to_alu_rob_d;
      end
   end

   assign to_alu_valid  = to_alu_valid_q;
   assign to_alu_op     = to_alu_op_q;
   assign to_alu_Vi     = to_alu_vi_q;
   assign to_alu_Vj     = to_alu_vj_q;
   assign to_alu_imm    = to_alu_imm_q;
   assign to_alu_pc     = to_alu_pc_q;
   assign to_alu_rob_id = to_alu_rob_q;

`ifdef RS_STAT_EN
   logic [31:0] stat_issue_cnt_q, stat_issue_cnt_d;
   logic [31:0] stat_dispatch_cnt_q, stat_dispatch_cnt_d;
   logic [31:0] stat_full_cycles_q, stat_full_cycles_d;

   // wrong_commit intentionally leaves these running totals alone.
   always_comb begin
      stat_issue_cnt_d    = stat_issue_cnt_q + 32'(alloc_en);
      stat_dispatch_cnt_d = stat_dispatch_cnt_q + 32'(disp_en);
      stat_full_cycles_d  = stat_full_cycles_q + 32'(rdy && rs_full);
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         stat_issue_cnt_q    <= '0;
         stat_dispatch_cnt_q <= '0;
         stat_full_cycles_q  <= '0;
      end else begin
         stat_issue_cnt_q    <= stat_issue_cnt_d;
         stat_dispatch_cnt_q <= stat_dispatch_cnt_d;
         stat_full_cycles_q  <= stat_full_cycles_d;
      end
   end

   assign stat_issue_cnt    = stat_issue_cnt_q;
   assign stat_dispatch_cnt = stat_dispatch_cnt_q;
   assign stat_full_cycles  = stat_full_cycles_q;
`endif

`ifndef SYNTHESIS
   // Issuing into a completely full station is a dispatcher protocol violation.
   no_issue_when_full: assert property (@(posedge clk) disable iff (flush)
      !(rdy && issue_valid && count_q == CNT_W'(RS_SIZE)));
`endif

endmodule

// File: tb/tb_reservation_station.sv
// Bench for reservation_station: directed scenarios plus randomized traffic
// checked against an entry-list reference model.
module tb_reservation_station;
   localparam int N = 16;

   logic        clk = 1'b0;
   logic        rst, rdy, wrong_commit, issue_valid;
   logic [6:0]  issue_op;
   logic [31:0] issue_imm, issue_pc, issue_Vi, issue_Vj;
   logic [4:0]  issue_Qi, issue_Qj, issue_rob_id;
   logic        rs_full;
   logic        alu_valid, lsb_valid;
   logic [4:0]  alu_rob_id, lsb_rob_id;
   logic [31:0] alu_res, lsb_res;
   logic        to_alu_valid;
   logic [6:0]  to_alu_op;
   logic [31:0] to_alu_Vi, to_alu_Vj, to_alu_imm, to_alu_pc;
   logic [4:0]  to_alu_rob_id;

   int n_vec = 0;
   int n_err = 0;

   reservation_station #(.RS_SIZE(N), .TAG_W(5)) dut (
      .clk(clk), .rst(rst), .rdy(rdy), .wrong_commit(wrong_commit),
      .issue_valid(issue_valid), .issue_op(issue_op), .issue_imm(issue_imm),
      .issue_pc(issue_pc), .issue_Qi(issue_Qi), .issue_Qj(issue_Qj),
      .issue_Vi(issue_Vi), .issue_Vj(issue_Vj), .issue_rob_id(issue_rob_id),
      .rs_full(rs_full), .alu_valid(alu_valid), .alu_rob_id(alu_rob_id),
      .alu_res(alu_res), .lsb_valid(lsb_valid), .lsb_rob_id(lsb_rob_id),
      .lsb_res(lsb_res), .to_alu_valid(to_alu_valid), .to_alu_op(to_alu_op),
      .to_alu_Vi(to_alu_Vi), .to_alu_Vj(to_alu_Vj), .to_alu_imm(to_alu_imm),
      .to_alu_pc(to_alu_pc), .to_alu_rob_id(to_alu_rob_id)
   );

   always #5 clk = ~clk;

   // Reference model: a slot list of waiting instructions plus the last ALU hand-off.
   typedef struct {
      bit        busy;
      bit [6:0]  op;
      bit [31:0] imm, pc, vi, vj;
      bit [4:0]  qi, qj, rob;
   } ent_t;
   ent_t      m_ent [N];
   bit        m_valid;
   bit [6:0]  m_op;
   bit [31:0] m_vi, m_vj, m_imm, m_pc;
   bit [4:0]  m_rob;

   function automatic int m_count();
      int c = 0;
      for (int i = 0; i < N; i++) if (m_ent[i].busy) c++;
      return c;
   endfunction

   function automatic bit snoop(input bit [4:0] q, output bit [31:0] v);
      v = '0;
      if (q == 0) return 1'b0;
      if (alu_valid && alu_rob_id == q) begin v = alu_res; return 1'b1; end
      if (lsb_valid && lsb_rob_id == q) begin v = lsb_res; return 1'b1; end
      return 1'b0;
   endfunction

   task automatic model_step();
      int sel = -1, fr = -1;
      bit [31:0] v;
      ent_t e;
      if (rst || wrong_commit) begin
         foreach (m_ent[i]) m_ent[i].busy = 0;
         {m_valid, m_op, m_vi, m_vj, m_imm, m_pc, m_rob} = '0;
         return;
      end
      if (!rdy) return;
      for (int i = N - 1; i >= 0; i--) begin
         if (m_ent[i].busy && m_ent[i].qi == 0 && m_ent[i].qj == 0) sel = i;
         if (!m_ent[i].busy) fr = i;
      end
      m_valid = (sel >= 0);
      if (sel >= 0) begin
         e = m_ent[sel];
         {m_op, m_vi, m_vj, m_imm, m_pc, m_rob} = {e.op, e.vi, e.vj, e.imm, e.pc, e.rob};
         m_ent[sel].busy = 0;
      end
      for (int i = 0; i < N; i++) if (m_ent[i].busy) begin
         if (snoop(m_ent[i].qi, v)) begin m_ent[i].vi = v; m_ent[i].qi = 0; end
         if (snoop(m_ent[i].qj, v)) begin m_ent[i].vj = v; m_ent[i].qj = 0; end
      end
      if (issue_valid && fr >= 0) begin
         e.busy = 1; e.op = issue_op; e.imm = issue_imm; e.pc = issue_pc; e.rob = issue_rob_id;
         e.vi = issue_Vi; e.qi = issue_Qi; e.vj = issue_Vj; e.qj = issue_Qj;
         if (snoop(issue_Qi, v)) begin e.vi = v; e.qi = 0; end
         if (snoop(issue_Qj, v)) begin e.vj = v; e.qj = 0; end
         m_ent[fr] = e;
      end
   endtask

   task automatic tick();
      model_step();
      @(posedge clk);
      #1;
   endtask

   task automatic idle_inputs();
      rdy = 1; wrong_commit = 0; issue_valid = 0; alu_valid = 0; lsb_valid = 0;
      alu_rob_id = 0; lsb_rob_id = 0; alu_res = 0; lsb_res = 0;
   endtask

   task automatic set_issue(input bit [4:0] qi, input bit [4:0] qj, input bit [31:0] vi,
                            input bit [31:0] vj, input bit [4:0] rob);
      issue_valid = 1; issue_op = 7'h01; issue_imm = 32'h100 + rob; issue_pc = 32'h4000 + 4 * rob;
      issue_Qi = qi; issue_Qj = qj; issue_Vi = vi; issue_Vj = vj; issue_rob_id = rob;
   endtask

   task automatic test_reset();
      idle_inputs(); rst = 1; issue_op = 0; issue_imm = 0; issue_pc = 0;
      issue_Qi = 0; issue_Qj = 0; issue_Vi = 0; issue_Vj = 0; issue_rob_id = 0;
      tick(); tick();
      rst = 0;
      n_vec++; if (to_alu_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid got=%b exp=0", to_alu_valid); end
      n_vec++; if (to_alu_rob_id !== 5'd0) begin n_err++; $display("FAIL reset_rob got=%0d exp=0", to_alu_rob_id); end
      n_vec++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL reset_full got=%b exp=0", rs_full); end
   endtask

   task automatic test_basic();
      set_issue(0, 0, 5, 7, 3);
      tick();
      issue_valid = 0;
      n_vec++; if (to_alu_valid !== 1'b0) begin n_err++; $display("FAIL basic_early got=%b exp=0", to_alu_valid); end
      tick();
      n_vec++; if ({to_alu_valid, to_alu_Vi, to_alu_Vj, to_alu_rob_id} !== {1'b1, 32'd5, 32'd7, 5'd3})
         begin n_err++; $display("FAIL basic_dispatch got=%b/%0d/%0d/%0d exp=1/5/7/3", to_alu_valid, to_alu_Vi, to_alu_Vj, to_alu_rob_id); end
      n_vec++; if ({to_alu_op, to_alu_imm, to_alu_pc} !== {7'h01, 32'h103, 32'h400c})
         begin n_err++; $display("FAIL basic_fields got=%h/%h/%h exp=01/103/400c", to_alu_op, to_alu_imm, to_alu_pc); end
      tick();
      n_vec++; if ({to_alu_valid, rs_full} !== 2'b00) begin n_err++; $display("FAIL basic_drain got=%b%b exp=00", to_alu_valid, rs_full); end
   endtask

   task automatic test_wakeup();
      set_issue(4, 0, 32'hdead, 1, 5);
      tick();
      issue_valid = 0;
      tick();
      alu_valid = 1; alu_rob_id = 4; alu_res = 32'h10;
      tick();
      alu_valid = 0;
      n_vec++; if (to_alu_valid !== 1'b0) begin n_err++; $display("FAIL wakeup_early got=%b exp=0", to_alu_valid); end
      tick();
      n_vec++; if ({to_alu_valid, to_alu_Vi, to_alu_Vj, to_alu_rob_id} !== {1'b1, 32'h10, 32'd1, 5'd5})
         begin n_err++; $display("FAIL wakeup_dispatch got=%b/%h/%h/%0d exp=1/10/1/5", to_alu_valid, to_alu_Vi, to_alu_Vj, to_alu_rob_id); end
      tick();
   endtask

   task automatic test_bypass();
      set_issue(6, 0, 32'hbad, 2, 8);
      lsb_valid = 1; lsb_rob_id = 6; lsb_res = 9;
      tick();
      issue_valid = 0; lsb_valid = 0;
      n_vec++; if (to_alu_valid !== 1'b0) begin n_err++; $display("FAIL bypass_early got=%b exp=0", to_alu_valid); end
      tick();
      n_vec++; if ({to_alu_valid, to_alu_Vi, to_alu_rob_id} !== {1'b1, 32'd9, 5'd8})
         begin n_err++; $display("FAIL bypass_dispatch got=%b/%0d/%0d exp=1/9/8", to_alu_valid, to_alu_Vi, to_alu_rob_id); end
      tick();
   endtask

   task automatic test_full();
      for (int i = 0; i < 15; i++) begin set_issue(7, 0, 0, i, 5'(i)); tick(); end
      issue_valid = 0; #1;
      n_vec++; if (rs_full !== 1'b0) begin n_err++; $display("FAIL full_15_idle got=%b exp=0", rs_full); end
      set_issue(7, 0, 0, 15, 15); #1;
      n_vec++; if (rs_full !== 1'b1) begin n_err++; $display("FAIL full_15_issue got=%b exp=1", rs_full); end
      tick();
      issue_valid = 0; #1;
      n_vec++; if (rs_full !== 1'b1) begin n_err++; $display("FAIL full_16 got=%b exp=1", rs_full); end
      alu_valid = 1; alu_rob_id = 7; alu_res = 32'h77;
      tick();
      alu_valid = 0;
      for (int i = 0; i < 16; i++) begin
         tick();
         n_vec++; if ({to_alu_valid, to_alu_rob_id, to_alu_Vi, to_alu_Vj} !== {1'b1, 5'(i), 32'h77, 32'(i)})
            begin n_err++; $display("FAIL full_drain_%0d got=%b/%0d/%h exp=1/%0d/77", i, to_alu_valid, to_alu_rob_id, to_alu_Vi, i); end
      end
      tick();
      n_vec++; if ({to_alu_valid, rs_full} !== 2'b00) begin n_err++; $display("FAIL full_empty got=%b%b exp=00", to_alu_valid, rs_full); end
   endtask

   task automatic test_flush();
      for (int i = 0; i < 8; i++) begin set_issue(7, 0, 0, 0, 5'(20 + i)); tick(); end
      issue_valid = 0; wrong_commit = 1;
      tick();
      wrong_commit = 0; #1;
      n_vec++; if ({rs_full, to_alu_valid, to_alu_rob_id} !== 7'd0)
         begin n_err++; $display("FAIL flush_state got=%b/%b/%0d exp=0/0/0", rs_full, to_alu_valid, to_alu_rob_id); end
      alu_valid = 1; alu_rob_id = 7; alu_res = 1;
      tick();
      alu_valid = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if (to_alu_valid !== 1'b0) begin n_err++; $display("FAIL flush_ghost_%0d got=%b exp=0", i, to_alu_valid); end
      end
   endtask

   task automatic test_rdy_hold();
      set_issue(0, 0, 32'h55, 1, 9);
      tick();
      set_issue(0, 0, 32'h66, 2, 10);
      tick();
      issue_valid = 0; rdy = 0;
      for (int i = 0; i < 3; i++) begin
         tick();
         n_vec++; if ({to_alu_valid, to_alu_rob_id, to_alu_Vi} !== {1'b1, 5'd9, 32'h55})
            begin n_err++; $display("FAIL rdy_hold_%0d got=%b/%0d/%h exp=1/9/55", i, to_alu_valid, to_alu_rob_id, to_alu_Vi); end
      end
      rdy = 1;
      tick();
      n_vec++; if ({to_alu_valid, to_alu_rob_id, to_alu_Vi} !== {1'b1, 5'd10, 32'h66})
         begin n_err++; $display("FAIL rdy_resume got=%b/%0d/%h exp=1/10/66", to_alu_valid, to_alu_rob_id, to_alu_Vi); end
      tick();
   endtask

   task automatic test_random();
      for (int c = 0; c < 600; c++) begin
         rdy = ($urandom_range(9) != 0);
         wrong_commit = ($urandom_range(59) == 0);
         issue_valid = ($urandom_range(2) != 0) && (m_count() < N);
         issue_op = 7'($urandom); issue_imm = $urandom; issue_pc = $urandom;
         issue_Qi = 5'($urandom_range(7)); issue_Qj = 5'($urandom_range(7));
         issue_Vi = $urandom; issue_Vj = $urandom; issue_rob_id = 5'($urandom);
         alu_valid = $urandom_range(1); alu_rob_id = 5'($urandom_range(7)); alu_res = $urandom;
         lsb_valid = $urandom_range(1); lsb_rob_id = 5'($urandom_range(7)); lsb_res = $urandom;
         #1;
         n_vec++; if (rs_full !== (m_count() + int'(issue_valid) >= N))
            begin n_err++; $display("FAIL rand_full c=%0d got=%b count=%0d", c, rs_full, m_count()); end
         tick();
         n_vec++; if ({to_alu_valid, to_alu_op, to_alu_Vi, to_alu_Vj, to_alu_imm, to_alu_pc, to_alu_rob_id} !==
                      {m_valid, m_op, m_vi, m_vj, m_imm, m_pc, m_rob})
            begin n_err++; $display("FAIL rand_out c=%0d got=%b/%h/%h/%h/%0d exp=%b/%h/%h/%h/%0d", c, to_alu_valid,
               to_alu_op, to_alu_Vi, to_alu_Vj, to_alu_rob_id, m_valid, m_op, m_vi, m_vj, m_rob); end
      end
      idle_inputs();
   endtask

   initial begin
      test_reset();
      test_basic();
      test_wakeup();
      test_bypass();
      test_full();
      test_flush();
      test_rdy_hold();
      test_random();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end
endmodule
